// File: rtl/nvme_irq_pkg.sv
// nvme_irq_pkg: shared state encodings and MSI vector helpers for the controller interrupt path
package nvme_irq_pkg;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_MSI_REQ = 5'b00010,
        S_CQ_ACK  = 5'b00100,
        S_GAP     = 5'b01000
    } irq_state_e;

    localparam logic [2:0] LP_MSI_MAX_MMENABLE = 3'd5;

    function automatic logic [7:0] msi_vec_mask(input logic [2:0] mm);
        logic [2:0] m;
        m = (mm > LP_MSI_MAX_MMENABLE) ? LP_MSI_MAX_MMENABLE : mm;
        return ~(8'hFF << m);
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// nvme_rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap
module nvme_rr_arbiter #(
    parameter int N  = 9,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_grant_i,
    output logic          grant_valid_o,
    output logic [GW-1:0] grant_idx_o
);

    int best;
    int off;

    // Distance of each requester from the search start; the smallest distance wins.
    always_comb begin
        best          = N;
        off           = 0;
        grant_idx_o   = '0;
        grant_valid_o = |req_i;
        for (int j = 0; j < N; j++) begin
            off = (j + 2 * N - int'(last_grant_i) - 1) % N;
            if (req_i[j] && off < best) begin
                best        = off;
                grant_idx_o = GW'(j);
            end
        end
    end

endmodule

// File: rtl/nvme_cq_msi_arb.sv
// nvme_cq_msi_arb: round-robin MSI issuer between the CQ checkers and the PCIe core interrupt port
module nvme_cq_msi_arb
    import nvme_irq_pkg::*;
#(
    parameter int         C_NUM_CQ         = 9,
    parameter logic [7:0] C_MSI_GAP_CYCLES = 8'h04
) (
    input  logic                pcie_user_clk,
    input  logic                pcie_user_rst_n,
    input  logic                pcie_msi_en,
    input  logic [2:0]          cfg_interrupt_mmenable,
    input  logic [C_NUM_CQ-1:0] cq_msi_irq_req,
    output logic [C_NUM_CQ-1:0] cq_msi_irq_ack,
    output logic                cfg_interrupt,
    output logic [7:0]          cfg_interrupt_di,
    input  logic                cfg_interrupt_rdy
);

    localparam int GW = $clog2(C_NUM_CQ);
    localparam logic [C_NUM_CQ-1:0] ACK_ONE = 1;

    irq_state_e          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d, last_q, last_d, arb_idx;
    logic                arb_valid;
    logic [7:0]          gap_q, gap_d, di_q, di_d;
    logic                irq_q, irq_d;
    logic [C_NUM_CQ-1:0] ack_q, ack_d;

    nvme_rr_arbiter #(.N(C_NUM_CQ), .GW(GW)) u_arb (
        .req_i         (cq_msi_irq_req),
        .last_grant_i  (last_q),
        .grant_valid_o (arb_valid),
        .grant_idx_o   (arb_idx)
    );

    always_ff @(posedge pcie_user_clk) begin
        if (!pcie_user_rst_n) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    // Once a request is issued it always runs to the ack, whatever happens to enable or request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = (pcie_msi_en && arb_valid) ? S_MSI_REQ : S_IDLE;
            S_MSI_REQ: state_d = cfg_interrupt_rdy ? S_CQ_ACK : S_MSI_REQ;
            S_CQ_ACK:  state_d = S_GAP;
            S_GAP:     state_d = (gap_q == 8'd0) ? S_IDLE : S_GAP;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d = (state_q == S_IDLE && state_d == S_MSI_REQ) ? arb_idx : grant_q;
        di_d    = (state_q == S_IDLE && state_d == S_MSI_REQ)
                ? 8'(arb_idx) & msi_vec_mask(cfg_interrupt_mmenable) : di_q;
        last_d  = (state_q == S_MSI_REQ && state_d == S_CQ_ACK) ? grant_q : last_q;
        gap_d   = (state_q == S_CQ_ACK) ? C_MSI_GAP_CYCLES
                : (state_q == S_GAP && gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
        irq_d   = (state_d == S_MSI_REQ);
        ack_d   = (state_d == S_CQ_ACK) ? ACK_ONE << grant_q : '0;
    end

    always_ff @(posedge pcie_user_clk) begin
        if (!pcie_user_rst_n) begin
            grant_q <= '0;
            last_q  <= GW'(C_NUM_CQ - 1);
            gap_q   <= 8'd0;
            di_q    <= 8'd0;
            irq_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            di_q    <= di_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
        end
    end

    assign cfg_interrupt    = irq_q;
    assign cfg_interrupt_di = di_q;
    assign cq_msi_irq_ack   = ack_q;

endmodule

// File: doc/nvme_cq_msi_arb.md
# nvme_cq_msi_arb

Per-controller MSI interrupt issuer. It collects the per-completion-queue `cq_msi_irq_req` levels from every CQ checker and arbitrates among them round-robin. It drives the PCIe core's MSI request handshake (`cfg_interrupt` / `cfg_interrupt_rdy`) with the vector mapped from the winning CQ. On core acceptance it returns a one-cycle `cq_msi_irq_ack` to the winning checker. It sits between the CQ checker array and the PCIe core configuration interrupt port.

## Interface
- `C_NUM_CQ`, 9, number of completion queues (admin CQ 0 plus I/O CQs 1..8); legal range 2..32.
- `C_MSI_GAP_CYCLES`, 8'h04, idle cycles enforced after each ack before the next arbitration; legal range 0..255.
- `pcie_user_clk` input 1: the only clock.
- `pcie_user_rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `pcie_user_clk`.
- `pcie_msi_en` input 1: MSI enabled in config space.
- `cfg_interrupt_mmenable` input 3: number of allocated vectors, as log2; values 6 and 7 are treated as 5.
- `cq_msi_irq_req` input C_NUM_CQ: per-CQ request level; held until that CQ's ack.
- `cq_msi_irq_ack` output C_NUM_CQ: per-CQ one-cycle ack pulse.
- `cfg_interrupt` output 1: MSI request to the PCIe core.
- `cfg_interrupt_di` output 8: MSI vector number, bits [7:5] always 0.
- `cfg_interrupt_rdy` input 1: core accepted the MSI request.

## Operation
- Grant index width `GW = clog2(C_NUM_CQ)`.
- `r_last_grant` resets to `C_NUM_CQ-1`, so CQ 0 has first priority after reset.
- States:
  - **S_IDLE**
    - If `pcie_msi_en==1` and `|cq_msi_irq_req`: register grant `g` and go to S_MSI_REQ. `g` is the first set request index searched from `r_last_grant+1` upward, wrapping modulo `C_NUM_CQ`.
    - Otherwise stay in S_IDLE.
  - **S_MSI_REQ**
    - `cfg_interrupt=1` and `cfg_interrupt_di = g & ((1<<mm)-1)`, where `mm = min(cfg_interrupt_mmenable,5)`.
    - `cfg_interrupt_di` is computed when entering the state and held stable for the whole state.
    - On `cfg_interrupt_rdy==1`: set `r_last_grant<=g` and go to S_CQ_ACK.
  - **S_CQ_ACK**
    - `cq_msi_irq_ack[g]=1` for exactly this one cycle.
    - Load the gap timer with `C_MSI_GAP_CYCLES`, then go to S_GAP.
  - **S_GAP**
    - When the timer is 0, go to S_IDLE; otherwise decrement it.
- Once S_MSI_REQ is entered, the request is never abandoned. This holds even if `pcie_msi_en` falls, `mmenable` changes, or `cq_msi_irq_req[g]` drops (for example, that CQ was reset): `cfg_interrupt` stays asserted until rdy, and the ack pulse still issues.
- `cfg_interrupt_rdy` is ignored in every state except S_MSI_REQ.
- While `pcie_msi_en==0`, requests are left pending; no grant and no ack are issued.

## Timing
- All outputs are registered. Reset values: `cfg_interrupt=0`, `cfg_interrupt_di=0`, `cq_msi_irq_ack=0`, state S_IDLE, gap timer 0, `r_last_grant=C_NUM_CQ-1`.
- Request sampled in S_IDLE at edge T gives `cfg_interrupt=1` from T+1.
- `cfg_interrupt_rdy` sampled high at edge R gives:
  - `cfg_interrupt=0` from R+1, satisfying the core's drop-after-rdy rule;
  - `cq_msi_irq_ack[g]` high during cycle R+1 only.
- After the ack cycle, the state is S_GAP for `C_MSI_GAP_CYCLES+1` cycles, then S_IDLE.
- Minimum spacing between successive `cfg_interrupt` rises is `C_MSI_GAP_CYCLES+4` cycles when rdy returns in the first request cycle.
- Compatibility with the CQ checker: the checker deasserts its request the cycle after the ack. Because the gap is always at least 1 cycle, the same request can never be re-granted.
- Synchronous reset wins over every state: any in-flight `cfg_interrupt` drops at the next edge with no ack. The PCIe core is reset by the same `pcie_user_rst_n`.

## Structure
- Shared package `nvme_irq_pkg`:
  - the state encodings (one-hot, 5 bits);
  - `LP_MSI_MAX_MMENABLE=3'd5`;
  - the vector-mask function.
- One natural sub-module, `nvme_rr_arbiter`. It is purely combinational: it takes the request vector and the last grant, and returns `grant_valid` and `grant_idx[GW-1:0]`. It is reusable by the SQ fetch arbitration.
- The FSM, vector mapping, gap timer and ack decode stay in `nvme_cq_msi_arb`.

## Test plan
- **Single request:** `mmenable=3`, raise `req[3]`, rdy returns 2 cycles after `cfg_interrupt` rises. Required: `cfg_interrupt` held 2 cycles with `di=3`, then `ack=9'h008` for exactly 1 cycle, no re-grant after the checker drops its request.
- **Round-robin fairness:** `req[0]` and `req[5]` held continuously, rdy immediate, `C_NUM_CQ=9`. Required: grant sequence 0,5,0,5; consecutive `cfg_interrupt` rises exactly 8 cycles apart with `C_MSI_GAP_CYCLES=4`.
- **Vector masking:**
  - `mmenable=0`, `req[7]` gives `di=0`;
  - `mmenable=2`, `req[7]` gives `di=3`;
  - `mmenable=7`, `req[8]` gives `di=8`.
- **Withdrawn request:** rdy delayed 20 cycles while `req[2]` drops and `pcie_msi_en` falls mid-request. Required: `cfg_interrupt` and `di` stable for all 20 cycles, `ack[2]` still pulses, then no new grant while `pcie_msi_en=0`.
- **Reset mid-request:** assert `pcie_user_rst_n=0` in S_MSI_REQ. Required: next edge gives `cfg_interrupt=0`, all acks 0; after release with `req[4]` and `req[1]` pending, CQ 1 is granted first.
- **MSI disabled:** `pcie_msi_en=0` with all requests high for 100 cycles. Required: `cfg_interrupt` never asserted. Enabling MSI then gives the first `cfg_interrupt` one cycle later with `di` for CQ 0.
